// File: rtl/hd_unmixer_seq_pkg.sv
// Shared packages for the HD unmixer: row width, the mixer permutations and the FSM state type.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents:
//   pkg_common          - MEM_ROW_WIDTH
//   pkg_mixer_permutate - mixer_permutate / mixer_permutate_inverse (1-bit perm_sel)
//   pkg_hd_unmixer      - unmixer_state_e
package pkg_common;
  localparam int MEM_ROW_WIDTH = 32;
endpackage

package pkg_mixer_permutate;
  import pkg_common::*;

  function automatic logic [MEM_ROW_WIDTH-1:0] bit_reverse(input logic [MEM_ROW_WIDTH-1:0] row);
    logic [MEM_ROW_WIDTH-1:0] r;
    for (int i = 0; i < MEM_ROW_WIDTH; i++) r[i] = row[MEM_ROW_WIDTH-1-i];
    return r;
  endfunction

  // perm_sel=0: rotate left by one; perm_sel=1: bit reversal (self-inverse).
  // The two do not commute, so the order of inverse steps matters.
  function automatic logic [MEM_ROW_WIDTH-1:0] mixer_permutate(input logic [MEM_ROW_WIDTH-1:0] row,
                                                               input logic perm_sel);
    return perm_sel ? bit_reverse(row) : {row[MEM_ROW_WIDTH-2:0], row[MEM_ROW_WIDTH-1]};
  endfunction

  function automatic logic [MEM_ROW_WIDTH-1:0] mixer_permutate_inverse(input logic [MEM_ROW_WIDTH-1:0] row,
                                                                       input logic perm_sel);
    return perm_sel ? bit_reverse(row) : {row[0], row[MEM_ROW_WIDTH-1:1]};
  endfunction
endpackage

package pkg_hd_unmixer;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} unmixer_state_e;
endpackage

// File: rtl/hd_unmixer_seq_step.sv
// One combinational inverse mixing step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no state.
// Ports: row_i (row in), perm_sel_i (which permutation to undo), row_o (row out).
module hd_unmixer_step
  import pkg_common::*;
  import pkg_mixer_permutate::*;
(
  input  logic [MEM_ROW_WIDTH-1:0] row_i,
  input  logic                     perm_sel_i,
  output logic [MEM_ROW_WIDTH-1:0] row_o
);
  assign row_o = mixer_permutate_inverse(row_i, perm_sel_i);
endmodule

// File: rtl/hd_unmixer_seq.sv
// Sequential unmixer: undoes an N-step mixing chain, last forward step first.
// Latency: valid_o n+1 cycles after accept (ceil(n/2)+1 with HD_UNMIXER_STEP2_EN).
// Backpressure: ready_o low while a job is in flight; result held in DONE until ready_i.
// Ports: clk_i/rst_ni (async active-low), clear_i (sync abort), valid_i/ready_o/row_i/
//   num_steps_i/sel_seq_i (job in), valid_o/ready_i/row_o (result out), busy_o.
// Optional macro HD_UNMIXER_STEP2_EN: two chained inverse steps per BUSY cycle.
module hd_unmixer_seq
  import pkg_common::*;
  import pkg_hd_unmixer::*;
#(
  parameter  int MAX_STEPS  = 8,
  localparam int STEP_CNT_W = $clog2(MAX_STEPS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [MEM_ROW_WIDTH-1:0] row_i,
  input  logic [STEP_CNT_W-1:0]    num_steps_i,
  input  logic [MAX_STEPS-1:0]     sel_seq_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [MEM_ROW_WIDTH-1:0] row_o,
  output logic                     busy_o
);
  localparam logic [STEP_CNT_W-1:0] MAX_CNT = STEP_CNT_W'(MAX_STEPS);
  localparam logic [STEP_CNT_W-1:0] ONE     = STEP_CNT_W'(1);

  unmixer_state_e           state_q;
  logic [MEM_ROW_WIDTH-1:0] row_q;
  logic [STEP_CNT_W-1:0]    cnt_q;
  logic [MAX_STEPS-1:0]     sel_q;

  logic [STEP_CNT_W-1:0]    cnt_in;
  logic [STEP_CNT_W-1:0]    cnt_nxt;
  logic [MEM_ROW_WIDTH-1:0] row_nxt;
  logic [MEM_ROW_WIDTH-1:0] row_hi;
  logic                     sel_hi;

  assign cnt_in = (num_steps_i > MAX_CNT) ? MAX_CNT : num_steps_i;

  // sel_q[cnt_q-1] as a mux, so cnt_q==0 simply selects nothing
  always_comb begin
    sel_hi = 1'b0;
    for (int k = 0; k < MAX_STEPS; k++)
      if (cnt_q == STEP_CNT_W'(k + 1)) sel_hi = sel_q[k];
  end

  hd_unmixer_step u_step_hi (.row_i(row_q), .perm_sel_i(sel_hi), .row_o(row_hi));

`ifdef HD_UNMIXER_STEP2_EN
  logic                     sel_lo;
  logic [MEM_ROW_WIDTH-1:0] row_lo;

  always_comb begin
    sel_lo = 1'b0;
    for (int k = 0; k < MAX_STEPS; k++)
      if (cnt_q == STEP_CNT_W'(k + 2)) sel_lo = sel_q[k];
  end

  hd_unmixer_step u_step_lo (.row_i(row_hi), .perm_sel_i(sel_lo), .row_o(row_lo));

  // Odd remainder: the final cycle applies a single step.
  assign row_nxt = (cnt_q >= STEP_CNT_W'(2)) ? row_lo : row_hi;
  assign cnt_nxt = (cnt_q >= STEP_CNT_W'(2)) ? cnt_q - STEP_CNT_W'(2) : cnt_q - ONE;
`else
  assign row_nxt = row_hi;
  assign cnt_nxt = cnt_q - ONE;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else if (clear_i) begin
      // Abort wins over both accept and the output handshake.
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          row_q   <= row_i;
          sel_q   <= sel_seq_i;
          cnt_q   <= cnt_in;
          state_q <= (cnt_in != '0) ? BUSY : DONE;
        end
        BUSY: begin
          row_q <= row_nxt;
          cnt_q <= cnt_nxt;
          if (cnt_nxt == '0) state_q <= DONE;
        end
        DONE: if (ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state flop, so reset is visible immediately.
  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q == BUSY) || (state_q == DONE);
  assign row_o   = valid_o ? row_q : '0;
endmodule

// File: tb/tb_hd_unmixer_seq.sv
// Bench for hd_unmixer_seq: directed and random jobs against a job-level model.
// Latency: n/a.
// Backpressure: ready_i driven fixed or random per cycle.
module tb_hd_unmixer_seq;
  import pkg_common::*;
  localparam int W  = MEM_ROW_WIDTH;
  localparam int MS = 8;
  localparam int SW = $clog2(MS + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni, clear_i, valid_i, ready_i;
  logic          ready_o, valid_o, busy_o;
  logic [W-1:0]  row_i, row_o;
  logic [SW-1:0] num_steps_i;
  logic [MS-1:0] sel_seq_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Job-level model: is a job in flight, when was it accepted, how many cycles to DONE, result.
  bit           job_active = 1'b0;
  int           acc_cyc = 0;
  int           lat = 0;
  logic [W-1:0] exp_row = '0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  hd_unmixer_seq #(.MAX_STEPS(MS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(ready_o), .row_i(row_i),
    .num_steps_i(num_steps_i), .sel_seq_i(sel_seq_i),
    .valid_o(valid_o), .ready_i(ready_i), .row_o(row_o), .busy_o(busy_o)
  );

  // Permutations by bit index: forward rotate-left / reverse, and their inverses.
  function automatic logic [W-1:0] m_fwd(input logic [W-1:0] r, input bit s);
    logic [W-1:0] o;
    for (int i = 0; i < W; i++) o[i] = s ? r[W-1-i] : r[(i + W - 1) % W];
    return o;
  endfunction

  function automatic logic [W-1:0] m_inv(input logic [W-1:0] r, input bit s);
    logic [W-1:0] o;
    for (int i = 0; i < W; i++) o[i] = s ? r[W-1-i] : r[(i + 1) % W];
    return o;
  endfunction

  function automatic int m_clamp(input int n);
    return (n > MS) ? MS : n;
  endfunction

  function automatic logic [W-1:0] m_decode(input logic [W-1:0] r, input int n, input logic [MS-1:0] s);
    logic [W-1:0] x;
    x = r;
    for (int j = m_clamp(n) - 1; j >= 0; j--) x = m_inv(x, s[j]);
    return x;
  endfunction

  function automatic int m_lat(input int n);
`ifdef HD_UNMIXER_STEP2_EN
    return (m_clamp(n) + 1) / 2;
`else
    return m_clamp(n);
`endif
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare, half a cycle after each active edge.
  always @(negedge clk_i) begin
    logic         ev;
    logic [W-1:0] er;
    ev = job_active && (cyc >= acc_cyc + lat);
    er = ev ? exp_row : '0;
    vectors++;
    if (valid_o !== ev || ready_o !== !job_active || busy_o !== job_active || row_o !== er) begin
      miscompares++;
      $display("FAIL cycle_cmp cyc=%0d valid=%b exp %b ready=%b exp %b busy=%b exp %b row=%h exp %h",
               cyc, valid_o, ev, ready_o, !job_active, busy_o, job_active, row_o, er);
    end
  end

  // Advance one edge and update the model from the inputs that edge sampled.
  task automatic tick();
    bit was_valid;
    @(posedge clk_i);
    #1;
    was_valid = job_active && ((cyc - 1) >= acc_cyc + lat);
    if (!rst_ni || clear_i) job_active = 1'b0;
    else if (job_active) begin
      if (was_valid && ready_i) job_active = 1'b0;
    end else if (valid_i) begin
      job_active = 1'b1;
      acc_cyc    = cyc;
      lat        = m_lat(int'(num_steps_i));
      exp_row    = m_decode(row_i, int'(num_steps_i), sel_seq_i);
    end
  endtask

  task automatic submit(input logic [W-1:0] r, input int n, input logic [MS-1:0] s);
    int k = 0;
    row_i = r; num_steps_i = SW'(n); sel_seq_i = s; valid_i = 1'b1;
    do begin
      tick();
      k++;
    end while (!(job_active && acc_cyc == cyc) && k < 50);
    valid_i = 1'b0;
    if (k >= 50) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  // Run until the job leaves; inputs are scrambled to show they are not re-sampled.
  task automatic drain(input bit rand_rdy, input bit rand_clr);
    int k = 0;
    while (job_active && k < 200) begin
      ready_i     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      clear_i     = rand_clr && ($urandom_range(0, 19) == 0);
      row_i       = $urandom;
      sel_seq_i   = MS'($urandom);
      num_steps_i = SW'($urandom);
      tick();
      k++;
    end
    clear_i = 1'b0;
    ready_i = 1'b1;
    if (job_active) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got job still active expected done within 200 cycles");
    end
  endtask

  initial begin
    logic [W-1:0] r, m, held;
    logic [MS-1:0] s;
    rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    row_i = '0; num_steps_i = '0; sel_seq_i = '0;
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_row", row_o, 0);
    #21 rst_ni = 1'b1;

    // Hand-computed values that pin the model itself.
    check("model_rot", m_decode(32'h0000_0003, 1, 8'h00), 32'h8000_0001);
    check("model_rev", m_decode(32'h0000_0003, 1, 8'h01), 32'hC000_0000);
    check("model_ord", m_decode(32'h0000_0003, 2, 8'h02), 32'h6000_0000);
    check("model_clamp", m_decode(32'h0000_0003, 15, 8'h00), 32'h0300_0000);

    // Zero steps: result next cycle, busy for one cycle only.
    submit(32'hDEAD_BEEF, 0, 8'hFF);
    check("t1_valid", valid_o, 1);
    check("t1_row", row_o, 32'hDEAD_BEEF);
    tick();
    check("t1_busy_low", busy_o, 0);

    // Literal two-step decode through the DUT.
    submit(32'h0000_0003, 2, 8'h02);
    repeat (m_lat(2)) tick();
    check("t_lit_row", row_o, 32'h6000_0000);
    drain(0, 0);

    // Forward mix with 0,1,0,1 then decode.
    r = 32'h1234_5678;
    m = m_fwd(m_fwd(m_fwd(m_fwd(r, 0), 1), 0), 1);
    check("t2_model", m_decode(m, 4, 8'h0A), r);
    submit(m, 4, 8'h0A);
    repeat (m_lat(4) - 1) tick();
    check("t2_not_yet", valid_o, 0);
    tick();
    check("t2_valid", valid_o, 1);
    check("t2_row", row_o, r);
    drain(0, 0);

    // Backpressure in DONE for six cycles.
    ready_i = 1'b0;
    submit($urandom, 3, MS'($urandom));
    repeat (m_lat(3)) tick();
    held = row_o;
    check("t3_valid0", valid_o, 1);
    repeat (6) begin
      row_i = $urandom;
      tick();
      check("t3_valid", valid_o, 1);
      check("t3_row", row_o, held);
      check("t3_ready", ready_o, 0);
    end
    drain(0, 0);

    // Clear in the second BUSY cycle of an 8-step job.
    submit($urandom, 8, MS'($urandom));
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t4_ready", ready_o, 1);
    check("t4_valid", valid_o, 0);
    repeat (10) tick();

    // Over-range step count clamps to MAX_STEPS.
    r = $urandom; s = MS'($urandom);
    submit(r, 15, s);
    repeat (m_lat(15)) tick();
    check("t5_row", row_o, m_decode(r, 8, s));
    drain(0, 0);

    // Asynchronous reset in the middle of BUSY.
    submit($urandom, 6, MS'($urandom));
    tick();
    #2 rst_ni = 1'b0;
    job_active = 1'b0;
    #1;
    check("t6_ready", ready_o, 1);
    check("t6_valid", valid_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_row", row_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    r = $urandom; s = MS'($urandom);
    submit(r, 5, s);
    repeat (m_lat(5)) tick();
    check("t6_after_row", row_o, m_decode(r, 5, s));
    drain(0, 0);

    // Random jobs with random backpressure and occasional aborts.
    repeat (40) begin
      submit($urandom, $urandom_range(0, 15), MS'($urandom));
      drain(1, 1);
      if ($urandom_range(0, 3) == 0) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
